// File: rtl/spi_ram_param.sv
// SPI-style framed RAM slave: 1 rw bit, 2-bit opcode, DATA_W payload.
// Address/data writes, address/data reads with optional post-increment.
module spi_ram_param #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic err
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(FW + 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, RX, EXEC, TX, WAIT} state_t;

  state_t              state, nxt;
  logic                rw;
  logic [FW-1:0]       rx_sr;
  logic [DATA_W-1:0]   tx_sr;
  logic [CW-1:0]       bit_cnt;
  logic [AW-1:0]       wr_addr, rd_addr;
  logic                rd_valid;
  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  logic [1:0]          opc;
  logic [DATA_W-1:0]   payload;
  logic [32:0]         pl_ext;
  logic                in_range, rx_last, tx_last;
  logic                do_wa, do_wd, do_ra, do_rd, reject;
  logic [DATA_W-1:0]   rdata;

  assign opc      = rx_sr[FW-1 -: 2];
  assign payload  = rx_sr[DATA_W-1:0];
  assign pl_ext   = 33'(payload);
  // full payload is range-checked; only the low AW bits are ever stored
  assign in_range = pl_ext < 33'(MEM_DEPTH);
  assign rx_last  = bit_cnt == CW'(FW - 1);
  assign tx_last  = bit_cnt == CW'(DATA_W - 1);
  assign rdata    = mem[rd_addr];

  function automatic logic [AW-1:0] inc_addr(input logic [AW-1:0] a);
    return (a == AW'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next state and one-cycle EXEC decisions; SS_n high aborts any frame
  always_comb begin
    nxt    = state;
    do_wa  = 1'b0;
    do_wd  = 1'b0;
    do_ra  = 1'b0;
    do_rd  = 1'b0;
    reject = 1'b0;
    case (state)
      IDLE:    if (!SS_n) nxt = CHK_CMD;
      CHK_CMD: nxt = SS_n ? IDLE : RX;
      RX:      if (SS_n) nxt = IDLE; else if (rx_last) nxt = EXEC;
      EXEC: begin
        if (SS_n) nxt = IDLE;
        else begin
          nxt = WAIT;
          if (rw != opc[1]) reject = 1'b1;
          else begin
            case (opc)
              2'b00: if (in_range) do_wa = 1'b1; else reject = 1'b1;
              2'b01: do_wd = 1'b1;
              2'b10: if (in_range) do_ra = 1'b1; else reject = 1'b1;
              default: begin
                if (rd_valid) begin
                  do_rd = 1'b1;
                  nxt   = TX;
                end else reject = 1'b1;
              end
            endcase
          end
        end
      end
      TX:      if (SS_n) nxt = IDLE; else if (tx_last) nxt = WAIT;
      WAIT:    if (SS_n) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // shift registers, counter, address registers, registered MISO/err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw       <= 1'b0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      bit_cnt  <= '0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      rd_valid <= 1'b0;
      MISO     <= 1'b0;
      err      <= 1'b0;
    end else begin
      MISO <= 1'b0;
      err  <= reject;
      case (state)
        CHK_CMD: begin
          rw      <= MOSI;
          bit_cnt <= '0;
        end
        RX: begin
          rx_sr   <= {rx_sr[FW-2:0], MOSI};
          bit_cnt <= bit_cnt + 1'b1;
        end
        TX: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (!SS_n && !tx_last) begin
            MISO  <= tx_sr[DATA_W-1];
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
          end
        end
        default: bit_cnt <= '0;
      endcase
      if (do_wa) wr_addr <= payload[AW-1:0];
      if (do_wd && AUTO_INC != 0) wr_addr <= inc_addr(wr_addr);
      if (do_ra) begin
        rd_addr  <= payload[AW-1:0];
        rd_valid <= 1'b1;
      end
      // first bit goes out the cycle right after EXEC
      if (do_rd) begin
        MISO  <= rdata[DATA_W-1];
        tx_sr <= {rdata[DATA_W-2:0], 1'b0};
        if (AUTO_INC != 0) rd_addr <= inc_addr(rd_addr);
      end
    end
  end

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (do_wd) mem[wr_addr] <= payload;
  end

endmodule

// File: tb/tb_spi_ram_param.sv
// Bench: two instances (A: depth 200, no auto-inc; B: depth 256, auto-inc)
// sharing clk/rst/MOSI, each with its own slave select.
module tb_spi_ram_param;

  logic clk = 1'b0;
  logic rst, mosi, ss_a, ss_b;
  logic miso_a, err_a, miso_b, err_b;
  int   total = 0, bad = 0;

  typedef struct packed {logic err; logic tx; logic [7:0] data;} exp_t;
  exp_t exp_q[$];

  // reference model state, index 0 = A, 1 = B
  int          m_wr[2], m_rd[2];
  bit          m_rv[2];
  logic [7:0]  m_ram[2][256];

  always #5 clk = ~clk;

  spi_ram_param #(.DATA_W(8), .MEM_DEPTH(200), .AUTO_INC(0)) u_a (
    .clk(clk), .rst(rst), .SS_n(ss_a), .MOSI(mosi), .MISO(miso_a), .err(err_a));
  spi_ram_param #(.DATA_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) u_b (
    .clk(clk), .rst(rst), .SS_n(ss_b), .MOSI(mosi), .MISO(miso_b), .err(err_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ss(input int inst, input logic v);
    if (inst == 0) ss_a = v; else ss_b = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wr[i] = 0; m_rd[i] = 0; m_rv[i] = 1'b0;
    end
  endtask

  function automatic int wrap(input int a, input int depth);
    return (a == depth - 1) ? 0 : a + 1;
  endfunction

  // full frame; rst_at >= 0 pulses reset during that TX sample
  task automatic frame(input int inst, input bit rw, input bit [1:0] opc,
                       input logic [7:0] pl, input int rst_at, input string tag);
    exp_t        e;
    int          depth, errs;
    bit          rej, extra;
    logic [7:0]  got;
    logic [9:0]  bits;
    logic        m, er;
    depth = (inst == 0) ? 200 : 256;
    rej = (rw != opc[1]) || (opc == 2'b11 && !m_rv[inst]) ||
          (!opc[0] && int'(pl) >= depth);
    e = '0;
    e.err = rej;
    if (!rej) begin
      case (opc)
        2'b00: m_wr[inst] = int'(pl);
        2'b01: begin
          m_ram[inst][m_wr[inst]] = pl;
          if (inst == 1) m_wr[inst] = wrap(m_wr[inst], depth);
        end
        2'b10: begin m_rd[inst] = int'(pl); m_rv[inst] = 1'b1; end
        default: begin
          e.tx = 1'b1;
          e.data = m_ram[inst][m_rd[inst]];
          if (inst == 1) m_rd[inst] = wrap(m_rd[inst], depth);
        end
      endcase
    end
    exp_q.push_back(e);

    @(negedge clk); set_ss(inst, 1'b0); mosi = 1'b0;
    @(negedge clk); mosi = rw;
    @(negedge clk);
    bits = {opc, pl};
    for (int i = 9; i >= 0; i--) begin
      mosi = bits[i];
      @(negedge clk);
    end
    mosi = 1'b0;
    got = '0; errs = 0; extra = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      m  = (inst == 0) ? miso_a : miso_b;
      er = (inst == 0) ? err_a : err_b;
      if (k < 8) got[7-k] = m; else if (m) extra = 1'b1;
      errs += int'(er);
      if (k == rst_at) begin
        #2 rst = 1'b1;
        #1 chk({tag, "_miso_rst"}, {31'd0, (inst == 0) ? miso_a : miso_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_ss(inst, 1'b1);
        model_reset();
        void'(exp_q.pop_front());
        @(negedge clk);
        return;
      end
    end
    e = exp_q.pop_front();
    chk({tag, "_err"}, errs, e.err ? 32'd1 : 32'd0);
    chk({tag, "_data"}, {24'd0, got}, e.tx ? {24'd0, e.data} : 32'd0);
    chk({tag, "_tail"}, {31'd0, extra}, 32'd0);
    set_ss(inst, 1'b1);
    @(negedge clk);
    @(negedge clk);
  endtask

  // frame dropped by SS_n after nbits payload/opcode bits
  task automatic partial(input int inst, input bit rw, input logic [9:0] bits,
                         input int nbits, input string tag);
    int errs;
    errs = 0;
    @(negedge clk); set_ss(inst, 1'b0); mosi = 1'b0;
    @(negedge clk); mosi = rw;
    @(negedge clk);
    for (int i = 9; i > 9 - nbits; i--) begin
      mosi = bits[i];
      @(negedge clk);
    end
    set_ss(inst, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      errs += int'((inst == 0) ? err_a : err_b);
    end
    chk({tag, "_err"}, errs, 32'd0);
  endtask

  initial begin
    rst = 1'b1; mosi = 1'b0; ss_a = 1'b1; ss_b = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_miso_a", {31'd0, miso_a}, 32'd0);
    chk("rst_err_a",  {31'd0, err_a},  32'd0);
    chk("rst_miso_b", {31'd0, miso_b}, 32'd0);
    chk("rst_err_b",  {31'd0, err_b},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // A: read-data without read-address, then write-data to default addr 0
    frame(0, 1, 2'b11, 8'h00, -1, "a_rd_novalid");
    frame(0, 0, 2'b01, 8'h5A, -1, "a_wd_addr0");
    frame(0, 1, 2'b10, 8'h00, -1, "a_ra_00");
    frame(0, 1, 2'b11, 8'h00, -1, "a_rd_00");
    // A: basic write/read round trip
    frame(0, 0, 2'b00, 8'h10, -1, "a_wa_10");
    frame(0, 0, 2'b01, 8'hA5, -1, "a_wd_a5");
    frame(0, 1, 2'b10, 8'h10, -1, "a_ra_10");
    frame(0, 1, 2'b11, 8'h00, -1, "a_rd_a5");
    // A: rejects leave addresses alone
    frame(0, 0, 2'b11, 8'h00, -1, "a_rw_mismatch");
    frame(0, 0, 2'b00, 8'hC8, -1, "a_wa_range");
    frame(0, 1, 2'b10, 8'hC8, -1, "a_ra_range");
    frame(0, 0, 2'b01, 8'h77, -1, "a_wd_77");
    frame(0, 1, 2'b11, 8'h00, -1, "a_rd_77");
    frame(0, 0, 2'b00, 8'hC7, -1, "a_wa_max");
    // A: aborted write-data, word unchanged, then a full frame works
    partial(0, 0, {2'b01, 8'h3C}, 5, "a_abort");
    frame(0, 1, 2'b11, 8'h00, -1, "a_rd_after_abort");
    frame(0, 0, 2'b00, 8'h10, -1, "a_wa_10b");
    frame(0, 0, 2'b01, 8'h3C, -1, "a_wd_3c");
    frame(0, 1, 2'b11, 8'h00, -1, "a_rd_3c");

    // B: auto-increment with wrap
    frame(1, 0, 2'b00, 8'hFF, -1, "b_wa_ff");
    frame(1, 0, 2'b01, 8'h11, -1, "b_wd_11");
    frame(1, 0, 2'b01, 8'h22, -1, "b_wd_22");
    frame(1, 1, 2'b10, 8'h00, -1, "b_ra_00");
    frame(1, 1, 2'b11, 8'h00, -1, "b_rd_22");
    frame(1, 1, 2'b10, 8'hFF, -1, "b_ra_ff");
    frame(1, 1, 2'b11, 8'h00, -1, "b_rd_11");
    frame(1, 1, 2'b11, 8'h00, -1, "b_rd_wrap");

    // reset mid-TX, then reads must be rejected
    frame(1, 1, 2'b10, 8'h00, -1, "b_ra_00b");
    frame(1, 1, 2'b11, 8'h00, 3,  "b_rd_rst");
    frame(1, 1, 2'b11, 8'h00, -1, "b_rd_after_rst");
    frame(0, 1, 2'b11, 8'h00, -1, "a_rd_after_rst");
    frame(1, 0, 2'b01, 8'h96, -1, "b_wd_addr0");
    frame(1, 1, 2'b10, 8'h00, -1, "b_ra_00c");
    frame(1, 1, 2'b11, 8'h00, -1, "b_rd_96");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
